alu_issue_stage: RTL and testbench

Command-buffering issue and capture stage wrapped around the team's combinational N-bit ALU. It accepts {op, a, b} commands over a valid/ready handshake into a DEPTH-entry FIFO. The FIFO head drives the ALU operand/opcode ports. The ALU result and flags are captured into a registered output slot with its own valid/ready handshake. Sticky carry/overflow status bits accumulate across results for software-visible error reporting.

---
 rtl/alu_issue_stage.sv | 121 ++++++++++++
 tb/tb_alu_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding an external combinational ALU, with a registered
// valid/ready result slot and sticky carry/overflow status.
module alu_issue_stage #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  output logic [2:0]                 alu_op,
  output logic [N-1:0]               alu_a,
  output logic [N-1:0]               alu_b,
  input  logic [N-1:0]               alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_carry,
  input  logic                       alu_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_result,
  output logic                       out_zero,
  output logic                       out_carry,
  output logic                       out_overflow,
  output logic                       sticky_carry,
  output logic                       sticky_overflow,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } cmd_t;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on count, so a full FIFO never accepts, even
  // in a cycle that also pops.
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign pop       = not_empty && slot_free;
  assign head      = mem[rd_ptr];

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (not_empty) begin
      alu_op = head.op;
      alu_a  = head.a;
      alu_b  = head.b;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_zero     <= alu_zero;
      out_carry    <= alu_carry;
      out_overflow <= alu_overflow;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // A capture that raises a flag wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      if (pop && alu_carry)    sticky_carry <= 1'b1;
      else if (clr_sticky)     sticky_carry <= 1'b0;
      if (pop && alu_overflow) sticky_overflow <= 1'b1;
      else if (clr_sticky)     sticky_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small 4-bit ALU model attached
// to the alu_* ports.
module tb_alu_issue_stage;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_result;
  logic          alu_zero;
  logic          alu_carry;
  logic          alu_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic          out_zero;
  logic          out_carry;
  logic          out_overflow;
  logic          sticky_carry;
  logic          sticky_overflow;
  logic          clr_sticky;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];

  alu_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_carry(out_carry), .out_overflow(out_overflow),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
    .clr_sticky(clr_sticky), .count(count)
  );

  // Attached ALU: carry is carry-out for ADD, borrow for SUB, the
  // shifted-out bit for shifts, and 0 for logic ops.
  always_comb begin
    logic [N:0] wide;
    wide         = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[N-1:0];
        alu_carry    = wide[N];
        alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      3'b001: begin
        wide         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = wide[N-1:0];
        alu_carry    = wide[N];
        alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: begin alu_result = alu_a << 1; alu_carry = alu_a[N-1]; end
      default: begin alu_result = alu_a >> 1; alu_carry = alu_a[0]; end
    endcase
    alu_zero = (alu_result == '0);
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  logic [2:0]   w_op [10] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd1};
  logic [N-1:0] w_a  [10] = '{4'd12, 4'd12, 4'd12, 4'd5, 4'd9, 4'd9, 4'd3, 4'd9, 4'd15, 4'd0};
  logic [N-1:0] w_b  [10] = '{4'd10, 4'd10, 4'd10, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 4'd1, 4'd1};
  logic [N-1:0] w_exp[10] = '{4'd8, 4'd14, 4'd6, 4'd10, 4'd2, 4'd4, 4'd7, 4'd7, 4'd0, 4'd15};

  initial begin
    int accepted;
    int sent;
    int received;
    int cycles;
    logic [N-1:0] held;

    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_zero", {alu_op, alu_a, alu_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_sticky", {sticky_carry, sticky_overflow}, 0);
    rst_n = 1'b1;
    step();

    // Single ADD 7+9
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 4'd7, 4'd9);
    step();
    drive(1'b0, 3'd0, '0, '0);
    check("add_count1", count, 1);
    check("add_not_yet", out_valid, 0);
    check("add_head_a", alu_a, 7);
    step();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 0);
    check("add_flags_zco", {out_zero, out_carry, out_overflow}, 3'b110);
    check("add_sticky_c", sticky_carry, 1);
    check("add_count0", count, 0);
    step();
    check("add_drain", out_valid, 0);

    // Signed overflow then SUB borrow, back to back
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_idle", {sticky_carry, sticky_overflow}, 0);
    drive(1'b1, 3'd0, 4'd5, 4'd4);
    step();
    drive(1'b1, 3'd1, 4'd3, 4'd5);
    step();
    drive(1'b0, 3'd0, '0, '0);
    check("ovf_result", out_result, 9);
    check("ovf_flags_co", {out_carry, out_overflow}, 2'b01);
    step();
    check("sub_valid", out_valid, 1);
    check("sub_result", out_result, 14);
    check("sub_flags_co", {out_carry, out_overflow}, 2'b10);
    check("sub_sticky", {sticky_carry, sticky_overflow}, 2'b11);
    step();

    // Back-pressure: 6 offered, 5 accepted
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd0, 4'(i + 1), 4'd1);
      if (in_ready) accepted++;
      step();
    end
    drive(1'b0, 3'd0, '0, '0);
    check("bp_accepted", accepted, 5);
    check("bp_count", count, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_head_result", out_result, 2);
    held = out_result;
    repeat (2) step();
    check("bp_hold_result", out_result, held);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_count", count, 4);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_drain_valid%0d", j), out_valid, 1);
      check($sformatf("bp_drain_result%0d", j), out_result, j + 2);
      step();
    end
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_count", count, 0);

    // Wrap ordering with random out_ready
    sent = 0;
    received = 0;
    cycles = 0;
    exp_q.delete();
    while (received < 10 && cycles < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) drive(1'b1, w_op[sent], w_a[sent], w_b[sent]);
      else           drive(1'b0, 3'd0, '0, '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("wrap_extra_result", out_result, 4'hx);
        else check($sformatf("wrap_result%0d", received), out_result, exp_q.pop_front());
        received++;
      end
      if (sent < 10 && in_ready) begin
        exp_q.push_back(w_exp[sent]);
        sent++;
      end
      step();
      cycles++;
    end
    drive(1'b0, 3'd0, '0, '0);
    check("wrap_received", received, 10);
    check("wrap_queue_empty", exp_q.size(), 0);
    out_ready = 1'b1;
    step();
    check("wrap_no_dup", out_valid, 0);

    // Sticky clear race
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    drive(1'b1, 3'd0, 4'd8, 4'd8);
    step();
    drive(1'b0, 3'd0, '0, '0);
    clr_sticky = 1'b1;
    step();
    check("race_result", out_result, 0);
    check("race_sticky_set", {sticky_carry, sticky_overflow}, 2'b11);
    step();
    clr_sticky = 1'b0;
    check("race_sticky_clr", {sticky_carry, sticky_overflow}, 0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'd15, 4'd1);
    step();
    drive(1'b1, 3'd2, 4'd12, 4'd10);
    step();
    drive(1'b1, 3'd3, 4'd1, 4'd2);
    step();
    drive(1'b0, 3'd0, '0, '0);
    check("mid_valid", out_valid, 1);
    check("mid_count", count, 2);
    check("mid_sticky_c", sticky_carry, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("mid_rst_sticky", {sticky_carry, sticky_overflow}, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 4'd6, 4'd3);
    step();
    drive(1'b0, 3'd0, '0, '0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", out_result, 2);
    step();
    check("post_rst_only_one", out_valid, 0);
    check("post_rst_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
